// File: rtl/instr_mem_loader.sv
// Instruction memory write-side loader: streams a program into an 8-entry memory
// over valid/ready, stalls the core until the load completes, and serves fetch reads.
module instr_mem_loader #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   load_len,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          busy,
  output logic          done,
  output logic          cpu_hold,
  output logic [AW:0]   word_count,
  output logic          jmp_err,
  input  logic [7:0]    PC,
  output logic [DW-1:0] Instruction_Code,
  output logic          oob
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] WADDR_ONE = AW'(1);
  localparam logic [AW:0]   LEN_MAX   = (AW+1)'(DEPTH);

  state_t          state_r;
  logic [AW-1:0]   waddr_r;
  logic [AW:0]     len_r;
  logic [AW:0]     word_count_r;
  logic            in_ready_r;
  logic            busy_r;
  logic            done_r;
  logic            cpu_hold_r;
  logic            jmp_err_r;
  logic [DW-1:0]   mem_r [DEPTH];

  logic            accept_s;
  logic            last_s;
  logic            start_load_s;
  logic            jump_bad_s;
  logic [AW:0]     len_next_s;

  assign in_ready   = in_ready_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign cpu_hold   = cpu_hold_r;
  assign word_count = word_count_r;
  assign jmp_err    = jmp_err_r;

  assign accept_s     = in_valid & in_ready_r;
  assign last_s       = ((word_count_r + CNT_ONE) == len_r);
  assign start_load_s = start & (state_r != LOAD);
  // Compared against the full program length so forward jumps are legal.
  assign jump_bad_s   = (in_data[7:6] == 2'b11) && (9'(in_data[5:0]) >= 9'(len_r));

  // Effective load length: 0 means a full memory, oversize requests are clamped.
  always_comb begin
    len_next_s = load_len;
    if (load_len == {(AW+1){1'b0}}) begin
      len_next_s = LEN_MAX;
    end else if (load_len > LEN_MAX) begin
      len_next_s = LEN_MAX;
    end else begin
      len_next_s = load_len;
    end
  end

  // Loader control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      waddr_r      <= {AW{1'b0}};
      len_r        <= {(AW+1){1'b0}};
      word_count_r <= {(AW+1){1'b0}};
      in_ready_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      cpu_hold_r   <= 1'b1;
      jmp_err_r    <= 1'b0;
    end else if (start_load_s) begin
      state_r      <= LOAD;
      waddr_r      <= {AW{1'b0}};
      len_r        <= len_next_s;
      word_count_r <= {(AW+1){1'b0}};
      in_ready_r   <= 1'b1;
      busy_r       <= 1'b1;
      done_r       <= 1'b0;
      cpu_hold_r   <= 1'b1;
      jmp_err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        LOAD: begin
          if (accept_s) begin
            waddr_r      <= waddr_r + WADDR_ONE;
            word_count_r <= word_count_r + CNT_ONE;
            if (jump_bad_s) begin
              jmp_err_r <= 1'b1;
            end else begin
              jmp_err_r <= jmp_err_r;
            end
            // Dropping in_ready with the last word guarantees no extra word is taken.
            if (last_s) begin
              state_r    <= DONE;
              in_ready_r <= 1'b0;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
              cpu_hold_r <= 1'b0;
            end else begin
              state_r <= LOAD;
            end
          end else begin
            state_r <= LOAD;
          end
        end
        DONE: begin
          state_r <= DONE;
        end
        default: begin
          state_r    <= IDLE;
          in_ready_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          cpu_hold_r <= 1'b1;
        end
      endcase
    end
  end

  // Instruction storage; reset clears every word, including partially loaded ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else if (accept_s) begin
      mem_r[waddr_r] <= in_data;
    end else begin
      mem_r[waddr_r] <= mem_r[waddr_r];
    end
  end

  // Zero-latency fetch port; out-of-range PCs fetch a nop.
  always_comb begin
    Instruction_Code = {DW{1'b0}};
    oob              = 1'b0;
    if ({1'b0, PC} < 9'(DEPTH)) begin
      Instruction_Code = mem_r[PC[AW-1:0]];
      oob              = 1'b0;
    end else begin
      Instruction_Code = {DW{1'b0}};
      oob              = 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader: loads, backpressure,
// full-depth loads, jump range checking, read bounds and mid-load reset.
module tb_instr_mem_loader;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] load_len;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic       cpu_hold;
  logic [3:0] word_count;
  logic       jmp_err;
  logic [7:0] PC;
  logic [7:0] Instruction_Code;
  logic       oob;

  int n_cmp;
  int n_fail;
  logic [7:0] wbuf [8];

  instr_mem_loader #(.DEPTH(8), .AW(3), .DW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .done(done), .cpu_hold(cpu_hold), .word_count(word_count),
    .jmp_err(jmp_err), .PC(PC), .Instruction_Code(Instruction_Code), .oob(oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts a load and streams wbuf words using a cyclic valid pattern.
  task automatic run_load(input logic [3:0] ll, input int nw, input logic [15:0] vpat,
                          output int acc, output int cyc, output bit early);
    logic rdy;
    @(negedge clk);
    start = 1'b1; load_len = ll; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    acc = 0; cyc = 0; early = 1'b0;
    while (acc < nw && cyc < 50) begin
      if (done === 1'b1) early = 1'b1;
      in_valid = vpat[cyc % 16];
      in_data  = wbuf[acc];
      rdy      = in_ready;
      @(negedge clk);
      if (in_valid && rdy) acc++;
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; load_len = 4'd0; in_data = 8'h00; in_valid = 1'b0; PC = 8'd0;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_hold: got %b want 1", cpu_hold); end
    n_cmp++; if (word_count !== 4'd0) begin n_fail++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
    n_cmp++; if (jmp_err !== 1'b0) begin n_fail++; $display("FAIL reset_jmp_err: got %b want 0", jmp_err); end
    n_cmp++; if (Instruction_Code !== 8'h00) begin n_fail++; $display("FAIL reset_mem0: got %h want 00", Instruction_Code); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_load();
    int acc, cyc; bit early;
    wbuf[0] = 8'h1B; wbuf[1] = 8'h5B; wbuf[2] = 8'h53; wbuf[3] = 8'hC5;
    wbuf[4] = 8'h1A; wbuf[5] = 8'h5A;
    run_load(4'd6, 6, 16'hFFFF, acc, cyc, early);
    n_cmp++; if (acc !== 6) begin n_fail++; $display("FAIL basic_accepted: got %0d want 6", acc); end
    n_cmp++; if (cyc !== 6) begin n_fail++; $display("FAIL basic_ready_cycles: got %0d want 6", cyc); end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b want 1", done); end
    n_cmp++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL basic_cpu_hold: got %b want 0", cpu_hold); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b want 0", busy); end
    n_cmp++; if (word_count !== 4'd6) begin n_fail++; $display("FAIL basic_word_count: got %0d want 6", word_count); end
    n_cmp++; if (jmp_err !== 1'b0) begin n_fail++; $display("FAIL basic_jmp_err: got %b want 0", jmp_err); end
    PC = 8'd3; #1;
    n_cmp++; if (Instruction_Code !== 8'hC5) begin n_fail++; $display("FAIL basic_pc3: got %h want C5", Instruction_Code); end
    PC = 8'd6; #1;
    n_cmp++; if (Instruction_Code !== 8'h00) begin n_fail++; $display("FAIL basic_pc6: got %h want 00", Instruction_Code); end
    // A seventh word offered after DONE must be refused.
    in_valid = 1'b1; in_data = 8'hEE;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_extra_ready: got %b want 0", in_ready); end
    @(negedge clk);
    in_valid = 1'b0; #1;
    n_cmp++; if (Instruction_Code !== 8'h00) begin n_fail++; $display("FAIL basic_extra_mem6: got %h want 00", Instruction_Code); end
    n_cmp++; if (word_count !== 4'd6) begin n_fail++; $display("FAIL basic_extra_count: got %0d want 6", word_count); end
  endtask

  task automatic test_backpressure();
    int acc, cyc; bit early;
    logic [7:0] exp [5];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44; exp[4] = 8'h1A;
    for (int i = 0; i < 4; i++) wbuf[i] = exp[i];
    run_load(4'd4, 4, 16'h0059, acc, cyc, early);
    n_cmp++; if (acc !== 4) begin n_fail++; $display("FAIL bp_accepted: got %0d want 4", acc); end
    n_cmp++; if (cyc !== 7) begin n_fail++; $display("FAIL bp_cycles: got %0d want 7", cyc); end
    n_cmp++; if (early !== 1'b0) begin n_fail++; $display("FAIL bp_early_done: got %b want 0", early); end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b want 1", done); end
    n_cmp++; if (word_count !== 4'd4) begin n_fail++; $display("FAIL bp_word_count: got %0d want 4", word_count); end
    // Address 4 keeps the word from the previous load.
    for (int i = 0; i < 5; i++) begin
      PC = 8'(i); #1;
      n_cmp++; if (Instruction_Code !== exp[i]) begin n_fail++; $display("FAIL bp_mem%0d: got %h want %h", i, Instruction_Code, exp[i]); end
    end
  endtask

  task automatic test_full_depth();
    int acc, cyc; bit early;
    for (int i = 0; i < 8; i++) wbuf[i] = 8'h40 + 8'(i);
    run_load(4'd0, 8, 16'hFFFF, acc, cyc, early);
    n_cmp++; if (acc !== 8) begin n_fail++; $display("FAIL full_accepted: got %0d want 8", acc); end
    n_cmp++; if (early !== 1'b0) begin n_fail++; $display("FAIL full_early_done: got %b want 0", early); end
    n_cmp++; if (word_count !== 4'd8) begin n_fail++; $display("FAIL full_word_count: got %0d want 8", word_count); end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b want 1", done); end
    in_valid = 1'b1; in_data = 8'hFF;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ninth_ready: got %b want 0", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      PC = 8'(i); #1;
      n_cmp++; if (Instruction_Code !== 8'h40 + 8'(i)) begin n_fail++; $display("FAIL full_mem%0d: got %h want %h", i, Instruction_Code, 8'h40 + 8'(i)); end
    end
  endtask

  task automatic test_jump_range();
    int acc, cyc; bit early;
    wbuf[0] = 8'h00; wbuf[1] = 8'hC5; wbuf[2] = 8'h00; wbuf[3] = 8'h00;
    wbuf[4] = 8'h00; wbuf[5] = 8'h00;
    run_load(4'd4, 4, 16'hFFFF, acc, cyc, early);
    n_cmp++; if (jmp_err !== 1'b1) begin n_fail++; $display("FAIL jmp_out_of_range: got %b want 1", jmp_err); end
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL jmp_done4: got %b want 1", done); end
    run_load(4'd6, 6, 16'hFFFF, acc, cyc, early);
    n_cmp++; if (jmp_err !== 1'b0) begin n_fail++; $display("FAIL jmp_in_range: got %b want 0", jmp_err); end
    n_cmp++; if (word_count !== 4'd6) begin n_fail++; $display("FAIL jmp_word_count: got %0d want 6", word_count); end
  endtask

  task automatic test_read_bounds();
    PC = 8'd8; #1;
    n_cmp++; if (Instruction_Code !== 8'h00) begin n_fail++; $display("FAIL rd_pc8_code: got %h want 00", Instruction_Code); end
    n_cmp++; if (oob !== 1'b1) begin n_fail++; $display("FAIL rd_pc8_oob: got %b want 1", oob); end
    PC = 8'hFF; #1;
    n_cmp++; if (Instruction_Code !== 8'h00) begin n_fail++; $display("FAIL rd_pcff_code: got %h want 00", Instruction_Code); end
    n_cmp++; if (oob !== 1'b1) begin n_fail++; $display("FAIL rd_pcff_oob: got %b want 1", oob); end
    PC = 8'd7; #1;
    n_cmp++; if (oob !== 1'b0) begin n_fail++; $display("FAIL rd_pc7_oob: got %b want 0", oob); end
    n_cmp++; if (Instruction_Code !== 8'h47) begin n_fail++; $display("FAIL rd_pc7_code: got %h want 47", Instruction_Code); end
  endtask

  task automatic test_reset_mid_load();
    int acc, cyc; bit early;
    @(negedge clk);
    start = 1'b1; load_len = 4'd5;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; in_data = 8'hAA;
    @(negedge clk);
    in_data = 8'hBB;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (word_count !== 4'd2) begin n_fail++; $display("FAIL mid_count_before: got %0d want 2", word_count); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    reset = 1'b0; PC = 8'd0; #1;
    n_cmp++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL mid_cpu_hold: got %b want 1", cpu_hold); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_cmp++; if (word_count !== 4'd0) begin n_fail++; $display("FAIL mid_word_count: got %0d want 0", word_count); end
    n_cmp++; if (Instruction_Code !== 8'h00) begin n_fail++; $display("FAIL mid_mem0: got %h want 00", Instruction_Code); end
    PC = 8'd1; #1;
    n_cmp++; if (Instruction_Code !== 8'h00) begin n_fail++; $display("FAIL mid_mem1: got %h want 00", Instruction_Code); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) wbuf[i] = 8'h01 + 8'(i);
    run_load(4'd5, 5, 16'hFFFF, acc, cyc, early);
    n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL mid_reload_done: got %b want 1", done); end
    n_cmp++; if (word_count !== 4'd5) begin n_fail++; $display("FAIL mid_reload_count: got %0d want 5", word_count); end
    PC = 8'd4; #1;
    n_cmp++; if (Instruction_Code !== 8'h05) begin n_fail++; $display("FAIL mid_reload_mem4: got %h want 05", Instruction_Code); end
    PC = 8'd5; #1;
    n_cmp++; if (Instruction_Code !== 8'h00) begin n_fail++; $display("FAIL mid_reload_mem5: got %h want 00", Instruction_Code); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_basic_load();
    test_backpressure();
    test_full_depth();
    test_jump_range();
    test_read_bounds();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Write side of the 8-entry, 8-bit instruction memory.
- Accepts a program as a stream of instruction bytes over a valid/ready handshake and writes them into consecutive memory locations starting at address 0.
- Holds the core in stall via cpu_hold until a load completes.
- Provides the combinational read port that instruction fetch uses: PC in, instruction byte out.

Parameters:
- DEPTH, 8, number of instruction words; must be a power of two, max 256.
- AW, 3, write-address width, equal to log2(DEPTH).
- DW, 8, instruction width; the field split below assumes 8.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin a program load.
- load_len  in  AW+1  number of words to load, sampled with start; 0 is treated as DEPTH.
- in_data  in  DW  instruction byte to write.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a word this cycle.
- busy  out  1  load in progress.
- done  out  1  load complete; stays high until the next start or reset.
- cpu_hold  out  1  stall/hold request to the core.
- word_count  out  AW+1  words written in the current or last load.
- jmp_err  out  1  sticky: a loaded jump targets an address >= the loaded length.
- PC  in  8  fetch read address.
- Instruction_Code  out  DW  memory word at PC.
- oob  out  1  PC >= DEPTH.

Behaviour:
- Instruction format: [7:6] opcode (00 mov, 01 add, 11 j), [5:3] Rd, [2:0] Rs, [5:0] jump target.
- Reset (asynchronous assert, synchronous release):
  - All memory words 8'h00. State IDLE. waddr 0, len 0.
  - in_ready 0, busy 0, done 0, cpu_hold 1, word_count 0, jmp_err 0.
- State machine: IDLE, LOAD, DONE.
  - IDLE: start=1 -> LOAD. Latch len = (load_len==0 ? DEPTH : min(load_len, DEPTH)). waddr<=0, word_count<=0, jmp_err<=0.
  - LOAD: in_ready=1 and busy=1. The registered in_ready is high the cycle after start.
    - Handshake in_valid & in_ready: Mem[waddr]<=in_data, waddr<=waddr+1, word_count<=word_count+1.
    - Accepting word number len -> DONE. in_ready is low from the next cycle, so no extra word is taken.
    - in_valid low: wait indefinitely; no timeout.
    - start while in LOAD: ignored.
  - DONE: done=1, cpu_hold=0, busy=0, in_ready=0. start=1 -> LOAD, with cpu_hold=1 and done=0 from the next cycle.
- cpu_hold is 1 in IDLE and LOAD, and 0 only in DONE.
- Jump check, on each accepted word:
  - If in_data[7:6]==2'b11 and in_data[5:0] >= len, set jmp_err.
  - jmp_err is cleared only by start or reset.
  - The check is against len, not against words written so far, so forward jumps are legal.
- Words at addresses >= len keep their prior contents; a new load does not clear them.
- Read port (combinational, zero latency):
  - Instruction_Code = Mem[PC[AW-1:0]] when PC < DEPTH.
  - Otherwise Instruction_Code = 8'h00 (mov R0,R0, a nop) and oob=1.
- Write/read same address, same cycle: the read returns the old word; the new word is visible after the clock edge.
- waddr wraps modulo DEPTH. It cannot exceed len-1 within a load.
- Reset asserted mid-load: immediate return to the reset state. Partially written words are cleared to 0 with the rest of memory.

Test Plan:
- Reset, then start with load_len=6 and stream 8'h1B, 8'h5B, 8'h53, 8'hC5, 8'h1A, 8'h5A with in_valid held high.
  - in_ready high for exactly 6 accepted cycles, then DONE.
  - done=1, cpu_hold=0, word_count=6, jmp_err=0.
  - PC=3 gives Instruction_Code=8'hC5; PC=6 gives 8'h00.
- Backpressure: load_len=4 with in_valid toggled 1,0,0,1,1,0,1.
  - Exactly 4 writes land at addresses 0..3 in order; DONE only after the 4th handshake.
- load_len=0: accepts 8 words (addresses 0..7) before DONE.
  - A 9th in_valid word is not accepted (in_ready=0) and memory is unchanged.
- Jump range: load_len=4 containing 8'hC5 (j 5) -> jmp_err=1 after DONE.
  - Reload with load_len=6 and the same word -> jmp_err=0.
- Read bounds: PC=8 and PC=8'hFF give Instruction_Code=8'h00 and oob=1; PC=7 gives oob=0.
- Reset mid-load after 2 of 5 words:
  - cpu_hold=1, busy=0, word_count=0, and Mem[0..1] read 8'h00 immediately.
  - A subsequent full load of 5 words works normally.
